// File: rtl/video_timing_gen.sv
// Raster timing generator: H/V counters, porch/sync geometry, pixel ce,
// per-frame H/V sync centering, sync polarity and blanked RGB output.
// Ports: clk_sys, reset_n (async, active low), ce_pix (pixel enable),
//   h_adj/v_adj (signed sync shift), rgb_in -> rgb_out (blanked),
//   hpos/vpos (live counters), hblank/vblank/de, hs/vs,
//   line_start/frame_start (one-ce pulses). Outputs lag hpos/vpos 1 ce.
module video_timing_gen #(
  parameter int H_ACTIVE = 288,
  parameter int H_FP     = 23,
  parameter int H_SYNC   = 31,
  parameter int H_BP     = 42,
  parameter int V_ACTIVE = 224,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 7,
  parameter int V_BP     = 29,
  parameter int HCW      = 9,
  parameter int VCW      = 9,
  parameter int RGBW     = 12,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter bit V_ADJ_EN = 1'b0
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            ce_pix,
  input  logic [3:0]      h_adj,
  input  logic [3:0]      v_adj,
  input  logic [RGBW-1:0] rgb_in,
  output logic [HCW-1:0]  hpos,
  output logic [VCW-1:0]  vpos,
  output logic [RGBW-1:0] rgb_out,
  output logic            hblank,
  output logic            vblank,
  output logic            de,
  output logic            hs,
  output logic            vs,
  output logic            line_start,
  output logic            frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_FP < 8 || H_BP < 8) begin : g_bad_hporch
    $error("video_timing_gen: H_FP and H_BP must be >= 8");
  end
  if (H_TOTAL > (1 << HCW)) begin : g_bad_hcw
    $error("video_timing_gen: HCW too small for H_TOTAL");
  end
  if (V_TOTAL > (1 << VCW)) begin : g_bad_vcw
    $error("video_timing_gen: VCW too small for V_TOTAL");
  end
  if (V_ADJ_EN && (V_FP < 8 || V_BP < 8)) begin : g_bad_vporch
    $error("video_timing_gen: V_FP and V_BP must be >= 8");
  end

  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT  = HCW'(H_ACTIVE);
  localparam logic [VCW-1:0] V_ACT  = VCW'(V_ACTIVE);

  localparam logic signed [HCW:0] HS_BASE =
    (HCW+1)'(H_ACTIVE + H_FP);
  localparam logic signed [HCW:0] HS_LEN =
    (HCW+1)'(H_SYNC);
  localparam logic signed [VCW:0] VS_BASE =
    (VCW+1)'(V_ACTIVE + V_FP);
  localparam logic signed [VCW:0] VS_LEN =
    (VCW+1)'(V_SYNC);

  logic [HCW-1:0]    hcnt;
  logic [VCW-1:0]    vcnt;
  logic signed [HCW:0] ha;
  logic signed [VCW:0] va;

  logic h_last, v_last;
  logic hb_n, vb_n;
  logic hs_on, vs_on;
  logic signed [HCW:0] hs_lo, hs_hi, hc_s;
  logic signed [VCW:0] vs_lo, vs_hi, vc_s;
  logic signed [HCW:0] ha_new;
  logic signed [VCW:0] va_new;

  assign hpos = hcnt;
  assign vpos = vcnt;

  assign h_last = (hcnt == H_LAST);
  assign v_last = (vcnt == V_LAST);
  assign hb_n   = (hcnt >= H_ACT);
  assign vb_n   = (vcnt >= V_ACT);

  assign hc_s  = $signed({1'b0, hcnt});
  assign hs_lo = HS_BASE + ha;
  assign hs_hi = hs_lo + HS_LEN;
  assign hs_on = (hc_s >= hs_lo) && (hc_s < hs_hi);

  assign vc_s  = $signed({1'b0, vcnt});
  assign vs_lo = VS_BASE + va;
  assign vs_hi = vs_lo + VS_LEN;
  assign vs_on = (vc_s >= vs_lo) && (vc_s < vs_hi);

  assign ha_new = {{(HCW-3){h_adj[3]}}, h_adj};
  assign va_new = V_ADJ_EN ? {{(VCW-3){v_adj[3]}}, v_adj} : '0;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hcnt        <= '0;
      vcnt        <= '0;
      ha          <= '0;
      va          <= '0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      de          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      rgb_out     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce_pix) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
      // New centering applies from the first pixel of the next frame
      if (h_last && v_last) begin
        ha <= ha_new;
        va <= va_new;
      end
      hblank      <= hb_n;
      vblank      <= vb_n;
      de          <= ~(hb_n | vb_n);
      hs          <= hs_on ? HS_POL : ~HS_POL;
      vs          <= vs_on ? VS_POL : ~VS_POL;
      rgb_out     <= (hb_n | vb_n) ? '0 : rgb_in;
      line_start  <= (hcnt == '0);
      frame_start <= (hcnt == '0) && (vcnt == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small raster (36 x 28) so whole
// frames fit in a short run; model tracks a linear pixel index.
module tb_video_timing_gen;

  localparam int HA = 16, HFP = 8, HSY = 4, HBP = 8;
  localparam int VA = 10, VFP = 8, VSY = 2, VBP = 8;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_pix = 1'b0;
  logic [3:0]  h_adj = '0;
  logic [3:0]  v_adj = '0;
  logic [11:0] rgb_in = '0;
  logic [5:0]  hpos;
  logic [4:0]  vpos;
  logic [11:0] rgb_out;
  logic hblank, vblank, de, hs, vs;
  logic line_start, frame_start;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HCW(6), .VCW(5), .RGBW(12),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .V_ADJ_EN(1'b1)
  ) dut (
    .clk_sys(clk), .reset_n(reset_n), .ce_pix(ce_pix),
    .h_adj(h_adj), .v_adj(v_adj), .rgb_in(rgb_in),
    .hpos(hpos), .vpos(vpos), .rgb_out(rgb_out),
    .hblank(hblank), .vblank(vblank), .de(de),
    .hs(hs), .vs(vs),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int n, m_ha, m_va, cyc;
  logic e_hb, e_vb, e_de, e_hs, e_vs, e_ls, e_fs;
  logic [11:0] e_rgb, last_rgb;
  bit last_ce;
  int ce_mode;
  bit rnd;

  bit fr_valid, all_fff;
  int gap, de_cnt, hs_cnt, vs_cnt, fff_cnt, fff_frames;
  bit prev_hs, prev_hb, prev_vs;
  bit hs_seen, fs_seen, vs_seen;
  int hs_at, hb_at, vs_at;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; m_ha = 0; m_va = 0;
    e_hb = 1'b1; e_vb = 1'b1; e_de = 1'b0;
    e_hs = !HS_POL; e_vs = !VS_POL;
    e_rgb = '0; e_ls = 1'b0; e_fs = 1'b0;
    last_ce = 1'b0; last_rgb = '0;
    fr_valid = 1'b0; all_fff = 1'b0;
    prev_hs = 1'b0; prev_hb = 1'b0; prev_vs = 1'b0;
  endtask

  task automatic model_step();
    int h, v, hs0, vs0;
    if (ce_pix) begin
      h = n % HT;
      v = (n / HT) % VT;
      hs0 = HA + HFP + m_ha;
      vs0 = VA + VFP + m_va;
      e_hb = (h >= HA);
      e_vb = (v >= VA);
      e_de = !(e_hb || e_vb);
      e_rgb = e_de ? rgb_in : 12'h000;
      e_hs = (h >= hs0 && h < hs0 + HSY) ? HS_POL : !HS_POL;
      e_vs = (v >= vs0 && v < vs0 + VSY) ? VS_POL : !VS_POL;
      e_ls = (h == 0);
      e_fs = (h == 0) && (v == 0);
      if (h == HT - 1 && v == VT - 1) begin
        m_ha = int'($signed(h_adj));
        m_va = int'($signed(v_adj));
      end
      n++;
      last_ce = 1'b1;
      last_rgb = rgb_in;
    end else begin
      last_ce = 1'b0;
    end
  endtask

  task automatic compare();
    chk("hpos", int'(hpos), n % HT);
    chk("vpos", int'(vpos), (n / HT) % VT);
    chk("hblank", int'(hblank), int'(e_hb));
    chk("vblank", int'(vblank), int'(e_vb));
    chk("de", int'(de), int'(e_de));
    chk("hs", int'(hs), int'(e_hs));
    chk("vs", int'(vs), int'(e_vs));
    chk("rgb_out", int'(rgb_out), int'(e_rgb));
    chk("line_start", int'(line_start), int'(e_ls));
    chk("frame_start", int'(frame_start), int'(e_fs));
  endtask

  task automatic accumulate();
    bit a;
    if (frame_start) begin
      if (fr_valid) begin
        chk("frame_len", gap, 1008);
        chk("frame_de", de_cnt, 160);
        chk("frame_hs", hs_cnt, 112);
        chk("frame_vs", vs_cnt, 72);
        if (all_fff) begin
          chk("frame_fff", fff_cnt, 160);
          fff_frames++;
        end
      end
      fr_valid = 1'b1;
      fs_seen = 1'b1;
      gap = 0; de_cnt = 0; hs_cnt = 0;
      vs_cnt = 0; fff_cnt = 0; all_fff = 1'b1;
    end
    gap++;
    if (de) de_cnt++;
    if (hs == HS_POL) hs_cnt++;
    if (vs == VS_POL) vs_cnt++;
    if (rgb_out == 12'hFFF) fff_cnt++;
    if (last_rgb != 12'hFFF) all_fff = 1'b0;
    a = (hs == HS_POL);
    if (a && !prev_hs) begin hs_at = int'(hpos); hs_seen = 1'b1; end
    prev_hs = a;
    if (hblank && !prev_hb) hb_at = int'(hpos);
    prev_hb = hblank;
    a = (vs == VS_POL);
    if (a && !prev_vs) begin vs_at = int'(vpos); vs_seen = 1'b1; end
    prev_vs = a;
  endtask

  task automatic tick();
    cyc++;
    if (ce_mode == 0) ce_pix = 1'b1;
    else if (ce_mode == 1) ce_pix = (cyc % 8 == 0);
    else if (ce_mode == 2) ce_pix = ($urandom_range(0, 3) != 0);
    else ce_pix = 1'b0;
    if (rnd) begin
      rgb_in = 12'($urandom);
      if ($urandom_range(0, 199) == 0) h_adj = 4'($urandom);
      if ($urandom_range(0, 199) == 0) v_adj = 4'($urandom);
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
    if (last_ce) accumulate();
  endtask

  task automatic wait_fs(input int lim);
    int k = 0;
    fs_seen = 1'b0;
    while (!fs_seen && k < lim) begin tick(); k++; end
    chk("fs_wait", int'(fs_seen), 1);
  endtask

  task automatic wait_hs(input int lim);
    int k = 0;
    hs_seen = 1'b0;
    while (!hs_seen && k < lim) begin tick(); k++; end
    chk("hs_wait", int'(hs_seen), 1);
  endtask

  task automatic wait_vs(input int lim);
    int k = 0;
    vs_seen = 1'b0;
    while (!vs_seen && k < lim) begin tick(); k++; end
    chk("vs_wait", int'(vs_seen), 1);
  endtask

  task automatic chk_reset();
    chk("rst_hblank", int'(hblank), 1);
    chk("rst_vblank", int'(vblank), 1);
    chk("rst_de", int'(de), 0);
    chk("rst_hs", int'(hs), int'(!HS_POL));
    chk("rst_vs", int'(vs), int'(!VS_POL));
    chk("rst_rgb", int'(rgb_out), 0);
    chk("rst_ls", int'(line_start), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_hpos", int'(hpos), 0);
    chk("rst_vpos", int'(vpos), 0);
  endtask

  task automatic first_ce();
    ce_mode = 0;
    tick();
    chk("first_ls", int'(line_start), 1);
    chk("first_fs", int'(frame_start), 1);
    chk("first_hpos", int'(hpos), 1);
  endtask

  initial begin
    int k;
    cyc = 0; rnd = 1'b0; ce_mode = 0; fff_frames = 0;
    model_reset();
    repeat (4) @(negedge clk) ce_pix = ~ce_pix;
    #1 chk_reset();
    @(negedge clk);
    reset_n = 1'b1;
    first_ce();

    wait_fs(3000);
    wait_fs(3000);
    wait_hs(100);
    chk("hs_start_adj0", hs_at, 25);
    chk("hb_start_adj0", hb_at, 17);
    h_adj = 4'd3;
    wait_hs(100);
    chk("hs_start_same_frame", hs_at, 25);
    wait_fs(3000);
    wait_hs(100);
    chk("hs_start_adj3", hs_at, 28);
    chk("hb_start_adj3", hb_at, 17);
    h_adj = 4'b1000;
    wait_fs(3000);
    wait_hs(100);
    chk("hs_start_adjm8", hs_at, 17);
    chk("hb_start_adjm8", hb_at, 17);
    h_adj = 4'd0;
    wait_fs(3000);
    wait_vs(1100);
    chk("vs_start_adj0", vs_at, 18);
    v_adj = 4'b1000;
    wait_fs(3000);
    wait_vs(1100);
    chk("vs_start_adjm8", vs_at, 10);
    v_adj = 4'd0;

    k = 0;
    while (int'(hpos) != 10 && k < 100) begin tick(); k++; end
    chk("hold_reach", int'(hpos), 10);
    ce_mode = 3;
    repeat (50) tick();
    chk("hold_hpos", int'(hpos), 10);
    ce_mode = 0;
    tick();
    chk("resume_hpos", int'(hpos), 11);

    rgb_in = 12'hFFF;
    ce_mode = 1;
    wait_fs(20000);
    wait_fs(20000);

    rnd = 1'b1;
    ce_mode = 2;
    repeat (6000) tick();

    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset();
    repeat (3) begin
      @(negedge clk);
      ce_pix = ~ce_pix;
    end
    #1 chk_reset();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    first_ce();
    ce_mode = 2;
    repeat (3000) tick();

    chk("fff_frames_seen", int'(fff_frames > 0), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
